// File: rtl/funct_generator_pkg.sv
// Shared types and constants for the function generator core and its prescaler.
package funct_generator_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DIV_WIDTH  = 16;
    localparam int DEFAULT_SAMPLE_MAX = (1 << DEFAULT_DATA_WIDTH) - 1;

    typedef enum logic [1:0] {
        WAVE_RAMP = 2'b00,
        WAVE_TRI  = 2'b01,
        WAVE_SQR  = 2'b10,
        WAVE_DC   = 2'b11
    } wave_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/funct_generator_prescaler.sv
// Rate divider: counts 0..div and raises tick on the terminal count, held at zero while clr is high.
module funct_generator_prescaler
    import funct_generator_pkg::*;
#(
    parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] count_q;
    logic [DIV_WIDTH-1:0] count_d;

    always_comb begin
        tick    = 1'b0;
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (count_q == div) begin
            tick    = 1'b1;
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/funct_generator_core.sv
// Waveform sample source: ramp/triangle/square/DC at a programmable tick rate,
// feeding a downstream sample register through sample/sample_en/sample_clr.
module funct_generator_core
    import funct_generator_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DIV_WIDTH  = DEFAULT_DIV_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            wave_sel,
    input  logic [DIV_WIDTH-1:0]  div,
    input  logic [DATA_WIDTH-1:0] step,
    output logic [DATA_WIDTH-1:0] sample,
    output logic                  sample_en,
    output logic                  sample_clr,
    output logic                  busy
);

    localparam logic [DATA_WIDTH-1:0] MAX = {DATA_WIDTH{1'b1}};

    state_e                state_q,      state_d;
    wave_e                 wave_q,       wave_d;
    logic [DIV_WIDTH-1:0]  div_q,        div_d;
    logic [DATA_WIDTH-1:0] step_q,       step_d;
    logic [DATA_WIDTH-1:0] acc_q,        acc_d;
    logic                  dir_down_q,   dir_down_d;
    logic [DATA_WIDTH-1:0] sample_q,     sample_d;
    logic                  sample_en_q,  sample_en_d;
    logic                  sample_clr_q, sample_clr_d;

    logic                  tick;
    logic                  prescale_clr;
    logic [DATA_WIDTH-1:0] ramp_next;
    logic [DATA_WIDTH:0]   tri_sum;

    // Prescaler idles at zero outside RUN so the first tick lands div+1 cycles into a run.
    assign prescale_clr = (state_q != ST_RUN);

    funct_generator_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (prescale_clr),
        .div   (div_q),
        .tick  (tick)
    );

    always_comb begin
        state_d      = state_q;
        wave_d       = wave_q;
        div_d        = div_q;
        step_d       = step_q;
        acc_d        = acc_q;
        dir_down_d   = dir_down_q;
        sample_d     = sample_q;
        sample_en_d  = 1'b0;
        sample_clr_d = 1'b0;
        ramp_next    = acc_q + step_q;
        tri_sum      = {1'b0, acc_q} + {1'b0, step_q};

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d      = ST_RUN;
                    wave_d       = wave_e'(wave_sel);
                    div_d        = div;
                    step_d       = step;
                    acc_d        = '0;
                    dir_down_d   = 1'b0;
                    sample_d     = '0;
                    sample_clr_d = 1'b1;
                end
            end
            ST_RUN: begin
                // A tick coinciding with stop is still issued before returning to IDLE.
                if (tick) begin
                    sample_en_d = 1'b1;
                    case (wave_q)
                        WAVE_RAMP: begin
                            acc_d    = ramp_next;
                            sample_d = ramp_next;
                        end
                        WAVE_TRI: begin
                            if (!dir_down_q) begin
                                if (tri_sum >= {1'b0, MAX}) begin
                                    acc_d      = MAX;
                                    dir_down_d = 1'b1;
                                end else begin
                                    acc_d = tri_sum[DATA_WIDTH-1:0];
                                end
                            end else begin
                                if (acc_q <= step_q) begin
                                    acc_d      = '0;
                                    dir_down_d = 1'b0;
                                end else begin
                                    acc_d = acc_q - step_q;
                                end
                            end
                            sample_d = acc_d;
                        end
                        WAVE_SQR: begin
                            acc_d    = ramp_next;
                            sample_d = ramp_next[DATA_WIDTH-1] ? '0 : MAX;
                        end
                        default: begin
                            sample_d = '0;
                        end
                    endcase
                end
                if (stop) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wave_q       <= WAVE_RAMP;
            div_q        <= '0;
            step_q       <= '0;
            acc_q        <= '0;
            dir_down_q   <= 1'b0;
            sample_q     <= '0;
            sample_en_q  <= 1'b0;
            sample_clr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wave_q       <= wave_d;
            div_q        <= div_d;
            step_q       <= step_d;
            acc_q        <= acc_d;
            dir_down_q   <= dir_down_d;
            sample_q     <= sample_d;
            sample_en_q  <= sample_en_d;
            sample_clr_q <= sample_clr_d;
        end
    end

    assign sample     = sample_q;
    assign sample_en  = sample_en_q;
    assign sample_clr = sample_clr_q;
    assign busy       = (state_q == ST_RUN);

endmodule

// File: tb/tb_funct_generator_core.sv
// Scoreboard bench for funct_generator_core: expected samples are queued at start and popped on each sample_en.
module tb_funct_generator_core;

    localparam int W  = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic [1:0]    wave_sel;
    logic [DW-1:0] div;
    logic [W-1:0]  step;
    logic [W-1:0]  sample;
    logic          sample_en;
    logic          sample_clr;
    logic          busy;

    int            checks = 0;
    int            fails  = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  exp_v;

    always #5 clk = ~clk;

    funct_generator_core #(
        .DATA_WIDTH (W),
        .DIV_WIDTH  (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .wave_sel   (wave_sel),
        .div        (div),
        .step       (step),
        .sample     (sample),
        .sample_en  (sample_en),
        .sample_clr (sample_clr),
        .busy       (busy)
    );

    // Pulses start for one edge, then scrambles the config inputs to prove they are latched.
    task automatic start_run(input logic [1:0] ws, input logic [DW-1:0] dv, input logic [W-1:0] st);
        @(negedge clk);
        wave_sel = ws;
        div      = dv;
        step     = st;
        start    = 1'b1;
        stop     = 1'b0;
        @(negedge clk);
        start    = 1'b0;
        wave_sel = 2'b11;
        div      = 16'd5;
        step     = 8'h11;
    endtask

    task automatic stop_run();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        wave_sel = 2'b00; div = '0; step = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sample, sample_en, sample_clr, busy} !== 11'd0) begin
            fails++;
            $display("[TB] FAIL reset_state sample=%h en=%b clr=%b busy=%b, want 00 0 0 0",
                     sample, sample_en, sample_clr, busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ramp();
        start_run(2'b00, 16'd0, 8'h40);
        checks++;
        if (sample_clr !== 1'b1 || busy !== 1'b1 || sample !== 8'h00 || sample_en !== 1'b0) begin
            fails++;
            $display("[TB] FAIL ramp_clr_cycle clr=%b busy=%b sample=%h en=%b, want 1 1 00 0",
                     sample_clr, busy, sample, sample_en);
        end
        exp_q = '{8'h40, 8'h80, 8'hC0, 8'h00, 8'h40};
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (sample_en !== 1'b1 || sample_clr !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("[TB] FAIL ramp_strobe k=%0d en=%b clr=%b busy=%b, want 1 0 1",
                         k, sample_en, sample_clr, busy);
            end
            if (sample_en === 1'b1 && exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (sample !== exp_v) begin
                    fails++;
                    $display("[TB] FAIL ramp_sample k=%0d got %h want %h", k, sample, exp_v);
                end
            end
        end
        stop_run();
    endtask

    task automatic test_triangle();
        start_run(2'b01, 16'd1, 8'h60);
        exp_q = '{8'h60, 8'hC0, 8'hFF, 8'h9F, 8'h3F, 8'h00, 8'h60};
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            checks++;
            if (sample_en !== ((k % 2) == 0)) begin
                fails++;
                $display("[TB] FAIL tri_strobe k=%0d got %b want %b", k, sample_en, (k % 2) == 0);
            end
            if (sample_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL tri_extra_sample k=%0d got %h want none", k, sample);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (sample !== exp_v) begin
                        fails++;
                        $display("[TB] FAIL tri_sample k=%0d got %h want %h", k, sample, exp_v);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL tri_missing got %0d left want 0", exp_q.size());
        end
        stop_run();
    endtask

    task automatic test_square();
        start_run(2'b10, 16'd0, 8'h40);
        exp_q = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || sample_en !== 1'b1) begin
                fails++;
                $display("[TB] FAIL sqr_busy_en k=%0d busy=%b en=%b, want 1 1", k, busy, sample_en);
            end
            if (sample_en === 1'b1 && exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (sample !== exp_v) begin
                    fails++;
                    $display("[TB] FAIL sqr_sample k=%0d got %h want %h", k, sample, exp_v);
                end
            end
        end
        stop_run();
    endtask

    task automatic test_stop_restart();
        start_run(2'b00, 16'd0, 8'h40);
        exp_q = '{8'h40, 8'h80, 8'hC0};
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (sample_en !== 1'b1 || sample !== exp_v) begin
                fails++;
                $display("[TB] FAIL stop_pre k=%0d en=%b sample=%h, want 1 %h", k, sample_en, sample, exp_v);
            end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        exp_v = exp_q.pop_front();
        checks++;
        if (busy !== 1'b0 || sample_en !== 1'b1 || sample !== exp_v) begin
            fails++;
            $display("[TB] FAIL stop_last_tick busy=%b en=%b sample=%h, want 0 1 %h",
                     busy, sample_en, sample, exp_v);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || sample_en !== 1'b0 || sample !== 8'hC0 || sample_clr !== 1'b0) begin
                fails++;
                $display("[TB] FAIL stop_hold k=%0d busy=%b en=%b sample=%h clr=%b, want 0 0 c0 0",
                         k, busy, sample_en, sample, sample_clr);
            end
        end
        start_run(2'b00, 16'd0, 8'h40);
        checks++;
        if (sample_clr !== 1'b1 || sample !== 8'h00 || busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL restart_clr clr=%b sample=%h busy=%b, want 1 00 1", sample_clr, sample, busy);
        end
        exp_q.push_back(8'h40);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++;
        if (sample_en !== 1'b1 || sample !== exp_v) begin
            fails++;
            $display("[TB] FAIL restart_first en=%b sample=%h, want 1 %h", sample_en, sample, exp_v);
        end
        stop_run();
    endtask

    task automatic test_start_stop_both();
        @(negedge clk);
        wave_sel = 2'b00; div = '0; step = 8'h40;
        start = 1'b1; stop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || sample_clr !== 1'b0 || sample_en !== 1'b0) begin
                fails++;
                $display("[TB] FAIL start_stop_both k=%0d busy=%b clr=%b en=%b, want 0 0 0",
                         k, busy, sample_clr, sample_en);
            end
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_dc_and_zero_step();
        start_run(2'b11, 16'd2, 8'h40);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if (sample_en !== ((k % 3) == 0) || sample !== 8'h00) begin
                fails++;
                $display("[TB] FAIL dc k=%0d en=%b sample=%h, want %b 00", k, sample_en, sample, (k % 3) == 0);
            end
        end
        stop_run();
        start_run(2'b10, 16'd0, 8'h00);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (sample_en !== 1'b1 || sample !== 8'hFF) begin
                fails++;
                $display("[TB] FAIL sqr_step0 k=%0d en=%b sample=%h, want 1 ff", k, sample_en, sample);
            end
        end
        stop_run();
        start_run(2'b01, 16'd0, 8'h00);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (sample_en !== 1'b1 || sample !== 8'h00) begin
                fails++;
                $display("[TB] FAIL tri_step0 k=%0d en=%b sample=%h, want 1 00", k, sample_en, sample);
            end
        end
        stop_run();
    endtask

    task automatic test_reset_midrun();
        start_run(2'b01, 16'd1, 8'h60);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if ({sample, sample_en, sample_clr, busy} !== 11'd0) begin
            fails++;
            $display("[TB] FAIL reset_midrun sample=%h en=%b clr=%b busy=%b, want 00 0 0 0",
                     sample, sample_en, sample_clr, busy);
        end
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_idle busy=%b want 0", busy);
        end
        start_run(2'b01, 16'd1, 8'h60);
        checks++;
        if (sample_clr !== 1'b1 || sample !== 8'h00) begin
            fails++;
            $display("[TB] FAIL reset_restart_clr clr=%b sample=%h, want 1 00", sample_clr, sample);
        end
        exp_q = '{8'h60, 8'hC0, 8'hFF};
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (sample_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL reset_restart_extra k=%0d got %h want none", k, sample);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (sample !== exp_v) begin
                        fails++;
                        $display("[TB] FAIL reset_restart_sample k=%0d got %h want %h", k, sample, exp_v);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL reset_restart_missing got %0d left want 0", exp_q.size());
        end
        stop_run();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_triangle();
        test_square();
        test_stop_restart();
        test_start_stop_both();
        test_dc_and_zero_step();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout got running want finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
